// File: rtl/adder_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the pipelined add/subtract unit and the ALU flag register.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } adder_flags_t;

endpackage

// File: rtl/adder_slice.sv
`timescale 1ns/1ps
// One CHUNK-bit slice of the carry-chained adder: sum, carry out, and the
// carry into its MSB so the top slice can form signed overflow.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s    = full[CHUNK-1:0];
    assign co   = full[CHUNK];
    // A sum bit is a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
    assign cm   = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
// Pipelined add/subtract: WIDTH bits split into STAGES carry-chained slices,
// one slice per stage, with a global stall and registered result/flags.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    function automatic adder_flags_t calc_flags(input logic [WIDTH-1:0] s,
                                                input logic co, input logic cm);
        adder_flags_t f;
        f.cout = co;
        f.ovf  = co ^ cm;
        f.zero = (s == '0);
        f.neg  = s[WIDTH-1];
        return f;
    endfunction

    logic              advance;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] take;

    // Registers between stage i and i+1; operands are carried full width, skewed.
    logic [WIDTH-1:0]  a_p   [NREG];
    logic [WIDTH-1:0]  b_p   [NREG];
    logic [WIDTH-1:0]  sum_p [NREG];
    logic              c_p   [NREG];

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic              src_c   [STAGES];
    logic [CHUNK-1:0]  slc_s   [STAGES];
    logic              slc_co  [STAGES];
    logic              slc_cm  [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];

    adder_flags_t      flags_p;

    assign advance   = !vld_p[STAGES-1] || out_ready;
    assign in_ready  = rst_n && advance;
    assign out_valid = vld_p[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p <= take;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_src
            assign take[0]    = in_valid;
            assign src_a[0]   = a;
            assign src_b[0]   = (sub == OP_SUB) ? ~b : b;
            assign src_sum[0] = '0;
            assign src_c[0]   = cin ^ sub;
        end else begin : g_src
            assign take[i]    = vld_p[i-1];
            assign src_a[i]   = a_p[i-1];
            assign src_b[i]   = b_p[i-1];
            assign src_sum[i] = sum_p[i-1];
            assign src_c[i]   = c_p[i-1];
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (src_a[i][i*CHUNK +: CHUNK]),
            .b  (src_b[i][i*CHUNK +: CHUNK]),
            .ci (src_c[i]),
            .s  (slc_s[i]),
            .co (slc_co[i]),
            .cm (slc_cm[i])
        );

        // Lower slices are already filled in; upper bits of src_sum are still zero.
        assign nxt_sum[i] = src_sum[i] | (WIDTH'(slc_s[i]) << (i * CHUNK));

        if (i < STAGES - 1) begin : g_reg
            // ---- stage i -> stage i+1 boundary ----
            always_ff @(posedge clk) begin
                if (advance && take[i]) begin
                    a_p[i]   <= src_a[i];
                    b_p[i]   <= src_b[i];
                    sum_p[i] <= nxt_sum[i];
                    c_p[i]   <= slc_co[i];
                end
            end
        end
    end

    // ---- final stage -> output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum     <= '0;
            flags_p <= '0;
        end else if (advance && take[STAGES-1]) begin
            sum     <= nxt_sum[STAGES-1];
            flags_p <= calc_flags(nxt_sum[STAGES-1], slc_co[STAGES-1], slc_cm[STAGES-1]);
        end
    end

    assign cout = flags_p.cout;
    assign ovf  = flags_p.ovf;
    assign zero = flags_p.zero;
    assign neg  = flags_p.neg;

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
// Self-checking bench for pipelined_adder: directed arithmetic cases, random
// backpressure traffic against an integer reference model, throughput and reset.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf, zero, neg;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, sub8, cout8, ovf8, zero8, neg8;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8), .neg(neg8)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          got = 0;
    bit          acc;
    logic [35:0] exp_q[$];
    int          out_cyc[$];
    logic        hold_chk = 1'b0;
    logic [31:0] hold_sum;
    logic [3:0]  hold_fl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Integer arithmetic: result = {sum, cout, ovf, zero, neg}
    function automatic logic [35:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic sb);
        longint ux, uy, sx, sy, u, s;
        logic [31:0] r;
        logic co, ov;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        if (sb) begin
            u = ux - uy - ci;
            s = sx - sy - ci;
            co = (u >= 0);
        end else begin
            u = ux + uy + ci;
            s = sx + sy + ci;
            co = (u > 64'sd4294967295);
        end
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r = u[31:0];
        return {r, co, ov, (r == 32'd0), r[31]};
    endfunction

    // Observe handshakes for the coming edge at the falling edge, then step past it.
    task automatic tick();
        @(negedge clk);
        if (hold_chk) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, hold_sum);
            chk("stall_flags", {cout, ovf, zero, neg}, hold_fl);
        end
        hold_chk = out_valid && !out_ready;
        hold_sum = sum;
        hold_fl  = {cout, ovf, zero, neg};
        acc = rst_n && in_valid && in_ready;
        if (acc) exp_q.push_back(ref_op(a, b, cin, sub));
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", exp_q.size(), 1);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("model_sum", sum, e[35:4]);
                chk("model_flags", {cout, ovf, zero, neg}, e[3:0]);
            end
            got++;
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic sb,
                            input logic [31:0] esum, input logic [3:0] efl);
        out_ready = 1'b1;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_early_valid"}, out_valid, 0);
            tick();
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_flags"}, {cout, ovf, zero, neg}, efl);
        tick();
    endtask

    task automatic rand_beat();
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int base;
        int idx;
        int pat[6] = '{1, 1, 0, 1, 0, 0};
        logic [31:0] ba[16], bb[16];
        logic        bc[16], bs[16];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero, neg}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);

        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010);
        directed("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
        directed("sub_brw",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0001);
        directed("sub_cin",  32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0005, 4'b1000);

        // Random beats under a repeating out_ready pattern
        for (int i = 0; i < 16; i++) begin
            ba[i] = $urandom; bb[i] = $urandom;
            bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
        end
        base = got; idx = 0;
        for (int t = 0; t < 300 && (got - base) < 16; t++) begin
            out_ready = pat[t % 6][0];
            if (idx < 16) begin
                in_valid = 1'b1; a = ba[idx]; b = bb[idx]; cin = bc[idx]; sub = bs[idx];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", got - base, 16);
        chk("bp_drained", exp_q.size(), 0);

        // Back-to-back with no backpressure
        base = got;
        for (int i = 0; i < 8; i++) begin
            rand_beat(); in_valid = 1'b1;
            chk("tp_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20 && (got - base) < 8; t++) tick();
        chk("tp_count", got - base, 8);
        chk("tp_spacing", out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-8], 7);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            rand_beat(); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_in_ready_low", in_ready, 0);
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_sum", sum, 0);
        chk("rstmid_flags", {cout, ovf, zero, neg}, 0);
        base = got;
        for (int i = 0; i < 2; i++) begin
            rand_beat(); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        chk("rstmid_count", got - base, 2);
        chk("rstmid_drained", exp_q.size(), 0);

        // Single-stage 8-bit variant
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
        chk("w8_in_ready", in_ready8, 1);
        tick();
        in_valid8 = 1'b0;
        chk("w8_valid", out_valid8, 1);
        chk("w8_sum", sum8, 8'h7F);
        chk("w8_flags", {cout8, ovf8, zero8, neg8}, 4'b1100);
        tick();
        chk("w8_idle", out_valid8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit: a WIDTH-bit operation is split into STAGES equal carry-chained slices, one slice per pipeline stage. It runs at one result per clock behind a valid/ready handshake with backpressure. It also reports carry/borrow, signed overflow, zero and negative flags. It replaces the flat combinational 32-bit adder wherever the carry chain limits the datapath clock (ALU execute stage, address generation).

## Interface
- WIDTH, 32: operand/result width; must be divisible by STAGES
- STAGES, 4: pipeline depth = number of slices; CHUNK = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; for sub, 1 = no borrow
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

## Operation
- Effective operation is a + (b XOR {WIDTH{sub}}) + (cin XOR sub):
  - add = a + b + cin
  - sub = a − b − cin
- Slice i (0 = LSB) adds bits [i*CHUNK +: CHUNK] in stage i, using the carry registered by stage i−1. Stage 0 uses cin XOR sub.
- Upper operand slices travel skewed through the pipeline with their beat. Already-computed lower sum slices travel forward with it.
- Each stage holds a valid bit. Beats never reorder, drop or duplicate.
- Stall is global: advance = !out_valid || out_ready. When advance is 0, every stage holds.
- in_ready = advance. A beat is accepted when in_valid && in_ready.
- Flags are computed in the final stage from the full beat:
  - cout = carry out of bit WIDTH−1
  - ovf = carry into MSB XOR carry out of MSB
  - zero = (sum == 0)
  - neg = sum MSB
- No arithmetic state persists between beats.
- Reset values: out_valid 0, sum 0, cout 0, ovf 0, zero 0, neg 0, all stage valid bits 0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. From the following cycle out_valid = 0, and no pre-reset beat ever appears after reset is released.
- While rst_n is low, in_ready is held 0.

## Timing
- Latency is STAGES edges. A beat accepted at edge k is presented on the outputs (out_valid = 1) after edge k+STAGES−1, plus any stall cycles.
- For STAGES = 1 the result is registered at the accept edge.
- Throughput is 1 beat/cycle while out_ready = 1.
- Outputs are registered and hold stable while out_valid && !out_ready.
- Accept and emit in the same cycle are allowed; the pipeline stays full.
- in_ready depends combinationally on out_ready. This is the only combinational in→out path.
- Critical path is one CHUNK-bit add plus the carry register.

## Structure
- Shared package adder_pkg:
  - OP_ADD / OP_SUB constants for the sub encoding
  - packed struct adder_flags_t {cout, ovf, zero, neg}, reused by the ALU flag register
- Sub-module adder_slice:
  - parameter CHUNK
  - combinational CHUNK-bit add with carry in and out
  - also exposes the carry into its MSB, so the top slice can form ovf
- Top level: generate loop of STAGES slices, skew/stage registers, valid chain, flag logic.

## Test plan
- WIDTH=32, STAGES=4: add 0xFFFFFFFF + 0x00000001, cin=0 → after 4 edges sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
- Add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, ovf=1, neg=1, cout=0.
- Sub 0x00000005 − 0x00000007, cin=0 → sum=0xFFFFFFFE, cout=0 (borrow), neg=1, ovf=0.
- Sub 0x00000009 − 0x00000003, cin=1 → sum=0x00000005, cout=1.
- Backpressure:
  - stimulus: 16 back-to-back random beats, out_ready toggling in a 1,1,0,1,0,0 pattern
  - check: every result matches the reference model, in order, with no loss or duplicate
  - check: outputs are stable during stalls
  - check: with out_ready held 1, one result per cycle
- Reset mid-stream: with 3 beats in flight, pull rst_n low for 1 cycle → next cycle out_valid=0 and all outputs 0; after release, only beats accepted post-reset emerge.
- WIDTH=8, STAGES=1: sub 0x80 − 0x01, cin=0 → 1 edge later sum=0x7F, ovf=1, cout=1, neg=0.
